// File: rtl/receptor_teclado_notas_pkg.sv
// receptor_teclado_notas_pkg: PS/2 receiver FSM states, scancode constants and the scancode-to-note map
// Shared with FSM_Modo_Reto so both blocks agree on note encoding.
package receptor_teclado_notas_pkg;
   typedef enum logic [2:0] {REPOSO, DATOS, PARIDAD, PARADA, DECODIFICA} estadoPs2_t;
   localparam logic [7:0] COD_BREAK = 8'hF0;
   localparam logic [7:0] COD_EXTENDIDO = 8'hE0;
   localparam logic [7:0] COD_A = 8'h1C;
   localparam logic [7:0] COD_B = 8'h32;
   localparam logic [7:0] COD_C = 8'h21;
   localparam logic [7:0] COD_D = 8'h23;
   localparam logic [7:0] COD_E = 8'h24;
   localparam logic [7:0] COD_F = 8'h2B;
   localparam logic [7:0] COD_G = 8'h34;
   localparam logic [7:0] ASCII_A = 8'h61;
   localparam logic [7:0] ASCII_B = 8'h62;
   localparam logic [7:0] ASCII_C = 8'h63;
   localparam logic [7:0] ASCII_D = 8'h64;
   localparam logic [7:0] ASCII_E = 8'h65;
   localparam logic [7:0] ASCII_F = 8'h66;
   localparam logic [7:0] ASCII_G = 8'h67;
   // Returns {valid, ascii}; valid is 0 for codes that are not note keys.
   function automatic logic [8:0] mapNota(input logic [7:0] cod);
      return cod == COD_A ? {1'b1, ASCII_A} :
             cod == COD_B ? {1'b1, ASCII_B} :
             cod == COD_C ? {1'b1, ASCII_C} :
             cod == COD_D ? {1'b1, ASCII_D} :
             cod == COD_E ? {1'b1, ASCII_E} :
             cod == COD_F ? {1'b1, ASCII_F} :
             cod == COD_G ? {1'b1, ASCII_G} : 9'h000;
   endfunction
endpackage

// File: rtl/receptor_teclado_notas_sincronizador.sv
// sincronizador_ps2: 2-FF synchronizers for ps2Clk/ps2Data plus ps2Clk falling-edge detect
// Ports: clk, reset (async, high), ps2Clk, ps2Data (async inputs),
//        ps2DataSinc (synchronized data), flancoBajada (1-cycle strobe on synchronized clk 1->0).
module sincronizador_ps2 (
   input  logic clk,
   input  logic reset,
   input  logic ps2Clk,
   input  logic ps2Data,
   output logic ps2DataSinc,
   output logic flancoBajada
);
   logic clk1, clk2, clk3, dat1, dat2;
   // Reset to 1 so an idle bus does not look like an edge after release.
   always_ff @(posedge clk or posedge reset)
      if (reset) {clk1, clk2, clk3, dat1, dat2} <= '1;
      else begin
         clk1 <= ps2Clk;
         clk2 <= clk1;
         clk3 <= clk2;
         dat1 <= ps2Data;
         dat2 <= dat1;
      end
   assign ps2DataSinc = dat2;
   assign flancoBajada = clk3 & ~clk2;
endmodule

// File: rtl/receptor_teclado_notas.sv
// receptor_teclado_notas: PS/2 keyboard receiver that turns note-key scancodes into ASCII 'a'..'g'
// Ports: clk, reset (async, high), ps2_clk, ps2_data (keyboard lines),
//        notaUsuario (last accepted note), datoListo (new-note pulse), errorTrama (frame-error/timeout pulse).
module receptor_teclado_notas
   import receptor_teclado_notas_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] notaUsuario,
   output logic       datoListo,
   output logic       errorTrama
);
   localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
   estadoPs2_t estado, estadoSig;
   logic flanco, datoSinc, paridad, flagBreak, flagExt, expira, aceptar, fallo, tramaOk;
   logic [2:0] contBits;
   logic [7:0] trama;
   logic [8:0] nota;
   logic [TW-1:0] contEspera;

   sincronizador_ps2 uSinc (
      .clk(clk), .reset(reset), .ps2Clk(ps2_clk), .ps2Data(ps2_data),
      .ps2DataSinc(datoSinc), .flancoBajada(flanco)
   );

   assign expira = estado != REPOSO && !flanco && contEspera == TW'(TIMEOUT_CICLOS);
   // In PARADA the current sample is the stop bit; odd parity over data+parity.
   assign tramaOk = datoSinc && ^{trama, paridad};
   assign nota = mapNota(trama);

   always_comb begin
      estadoSig = estado;
      aceptar = 1'b0;
      fallo = expira;
      if (expira || estado == DECODIFICA) estadoSig = REPOSO;
      else if (flanco)
         case (estado)
            REPOSO:  estadoSig = datoSinc ? REPOSO : DATOS;
            DATOS:   estadoSig = contBits == 3'd7 ? PARIDAD : DATOS;
            PARIDAD: estadoSig = PARADA;
            PARADA: begin
               estadoSig = tramaOk ? DECODIFICA : REPOSO;
               fallo = !tramaOk;
               // Outputs are registered here so they appear during the DECODIFICA cycle.
               aceptar = tramaOk && nota[8] && !flagBreak && !flagExt;
            end
            default: estadoSig = REPOSO;
         endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         estado <= REPOSO;
         contBits <= '0;
         trama <= '0;
         paridad <= 1'b0;
         contEspera <= '0;
         flagBreak <= 1'b0;
         flagExt <= 1'b0;
         notaUsuario <= '0;
         datoListo <= 1'b0;
         errorTrama <= 1'b0;
      end else begin
         estado <= estadoSig;
         datoListo <= aceptar;
         errorTrama <= fallo;
         if (aceptar) notaUsuario <= nota[7:0];
         if (flanco) contEspera <= '0;
         else if (contEspera != TW'(TIMEOUT_CICLOS)) contEspera <= contEspera + 1'b1;
         if (expira) contBits <= '0;
         else if (flanco)
            case (estado)
               REPOSO: contBits <= '0;
               DATOS: begin
                  trama[contBits] <= datoSinc;
                  contBits <= contBits + 3'd1;
               end
               PARIDAD: paridad <= datoSinc;
               default: ;
            endcase
         // Break/extended prefixes swallow the following code.
         if (estado == DECODIFICA) begin
            if (trama == COD_BREAK) flagBreak <= 1'b1;
            else if (trama == COD_EXTENDIDO) flagExt <= 1'b1;
            else if (flagBreak || flagExt) {flagBreak, flagExt} <= 2'b00;
         end
      end
endmodule

// File: tb/tb_receptor_teclado_notas.sv
// tb_receptor_teclado_notas: directed and random PS/2 frames checked against a frame-level model
module tb_receptor_teclado_notas;
   logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [7:0] notaUsuario;
   logic datoListo, errorTrama;
   int checks = 0, failures = 0;
   int cyc = 0, dlCount = 0, errCount = 0, dlCyc = 0, stopCyc = 0, bothCount = 0, h = 10;
   logic [7:0] scTab [7] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34};
   logic [7:0] mNota = 8'h00;
   bit mBrk = 0, mExt = 0;

   receptor_teclado_notas #(.TIMEOUT_CICLOS(100)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .notaUsuario(notaUsuario), .datoListo(datoListo), .errorTrama(errorTrama)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (datoListo) begin dlCount++; dlCyc = cyc; end
      if (errorTrama) errCount++;
      if (datoListo && errorTrama) bothCount++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic waitCyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sendBit(input logic b);
      ps2_data = b;
      waitCyc(h);
      ps2_clk = 1'b0;
      stopCyc = cyc;
      waitCyc(h);
      ps2_clk = 1'b1;
   endtask

   task automatic sendFrame(input logic [7:0] code, input bit badPar, input bit badStop, input string tag);
      logic par;
      bit expDl, expErr;
      int idx;
      par = ~^code ^ badPar;
      dlCount = 0;
      errCount = 0;
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(code[i]);
      sendBit(par);
      sendBit(~badStop);
      waitCyc(10);
      expDl = 0;
      expErr = badPar || badStop;
      idx = -1;
      for (int i = 0; i < 7; i++) if (scTab[i] == code) idx = i;
      if (!expErr) begin
         if (code == 8'hF0) mBrk = 1;
         else if (code == 8'hE0) mExt = 1;
         else if (mBrk || mExt) begin mBrk = 0; mExt = 0; end
         else if (idx >= 0) begin mNota = 8'h61 + 8'(idx); expDl = 1; end
      end
      chk({tag, "_datoListo"}, dlCount, int'(expDl));
      chk({tag, "_errorTrama"}, errCount, int'(expErr));
      chk({tag, "_nota"}, notaUsuario, mNota);
      if (expDl) chk({tag, "_latencia"}, dlCyc - stopCyc, 3);
   endtask

   initial begin
      waitCyc(4);
      chk("reset_nota", notaUsuario, 0);
      chk("reset_datoListo", datoListo, 0);
      chk("reset_errorTrama", errorTrama, 0);
      reset = 1'b0;
      waitCyc(5);
      sendFrame(8'h1C, 0, 0, "a");
      sendFrame(8'hF0, 0, 0, "break");
      sendFrame(8'h1C, 0, 0, "a_soltada");
      sendFrame(8'h21, 1, 0, "paridad_mal");
      sendFrame(8'h15, 0, 0, "no_mapeado");
      sendFrame(8'h23, 0, 1, "parada_mal");
      sendFrame(8'hE0, 0, 0, "extendido");
      sendFrame(8'h24, 0, 0, "e_extendida");
      sendFrame(8'h2B, 0, 0, "f");
      // Partial frame then silence: timeout must fire once and leave note/flags alone.
      dlCount = 0;
      errCount = 0;
      sendBit(1'b0);
      for (int i = 0; i < 4; i++) sendBit(1'(8'h32 >> i));
      waitCyc(150);
      chk("timeout_err", errCount, 1);
      chk("timeout_dl", dlCount, 0);
      chk("timeout_nota", notaUsuario, mNota);
      sendFrame(8'h32, 0, 0, "b_tras_timeout");
      for (int k = 0; k < 30; k++) begin
         int r;
         logic [7:0] c;
         h = $urandom_range(5, 30);
         r = $urandom_range(0, 9);
         c = r < 7 ? scTab[r] : r == 7 ? 8'hF0 : r == 8 ? 8'hE0 : 8'($urandom);
         sendFrame(c, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $sformatf("rnd%0d", k));
      end
      h = 10;
      sendFrame(8'h1C, 0, 0, "a_final");
      // Reset in mid-frame after 6 bits.
      sendBit(1'b0);
      for (int i = 0; i < 5; i++) sendBit(1'(8'h34 >> i));
      reset = 1'b1;
      #1;
      chk("rst_mid_nota", notaUsuario, 0);
      chk("rst_mid_datoListo", datoListo, 0);
      chk("rst_mid_errorTrama", errorTrama, 0);
      mNota = 8'h00;
      mBrk = 0;
      mExt = 0;
      waitCyc(3);
      reset = 1'b0;
      waitCyc(5);
      sendFrame(8'h34, 0, 0, "g_tras_reset");
      chk("nunca_ambos", bothCount, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
